masked_xor_share_sequencer: RTL and testbench
=============================================

# masked_xor_share_sequencer

Front-end and capture stage for the 2-share masked XOR gate (inputs a0/a1/b0/b1/r0/r1/r2, outputs y0/y1):
- Takes unmasked operand bits over a valid/ready handshake.
- Splits them into Boolean shares using an internal LFSR and drives fresh gate randomness.
- Holds the gate inputs stable for a programmable settle window, then registers the output shares and presents them downstream with valid/ready.

## Interface

Parameters:
- SEED, 16'hACE1, LFSR reset/reload value; must be non-zero.
- SETTLE, 2, cycles gate inputs are held before output capture; legal range 1..15.

Ports (clock and reset are fixed: one clock, asynchronous active-low reset):
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- a  in  1  unmasked operand a
- b  in  1  unmasked operand b
- seed_load  in  1  synchronous LFSR reload strobe
- seed_in  in  16  reload value
- a0, a1  out  1 each  shares of a to gate
- b0, b1  out  1 each  shares of b to gate
- r0, r1, r2  out  1 each  fresh gate randomness
- y0_in, y1_in  in  1 each  gate output shares
- out_valid  out  1  captured shares valid
- out_ready  in  1  downstream accepts
- y0, y1  out  1 each  registered output shares

## Operation

LFSR:
- 16-bit Fibonacci LFSR, state s. fb = s[15]^s[13]^s[12]^s[10]; next = {s[14:0], fb}.
- Steps every cycle in every FSM state.
- seed_load has priority over stepping: s <= seed_in, or s <= SEED if seed_in == 0. seed_load does not affect the FSM.

Accept (in_valid & in_ready at an edge), using the current s before it steps:
- a0 = s[0], a1 = a ^ s[0]
- b0 = s[1], b1 = b ^ s[1]
- r0 = s[2], r1 = s[3], r2 = s[4]
- If seed_load is asserted on the same edge, share generation still uses the pre-load s.

FSM states:
- IDLE: in_ready = 1. On accept: load share/random registers, cnt <= SETTLE-1, go SETTLE.
- SETTLE: gate inputs frozen. If cnt == 0: y0 <= y0_in, y1 <= y1_in, go HOLD. Else cnt <= cnt-1.
- HOLD: out_valid = 1; y0/y1 stable. On out_ready: go IDLE.

Other rules:
- Share and random registers hold their last values until the next accept. They are never cleared outside reset, which avoids extra transitions on gate inputs.
- Output shares are never recombined inside the block.
- in_ready and out_valid are decoded from registered state, with no combinational path from in_valid or out_ready.

## Timing

Reset values (async, on rst_n low):
- State IDLE; s = SEED; cnt = 0.
- a0, a1, b0, b1, r0, r1, r2, y0, y1 = 0.
- out_valid = 0; in_ready = 1 once rst_n is high.

Latency:
- Accept at edge N: gate inputs change after edge N and stay constant through edge N+SETTLE.
- Capture at edge N+SETTLE; out_valid high from N+SETTLE until the out_ready edge M.
- in_ready high from edge M onward, so the next accept is possible at M+1.
- With out_ready tied high, the minimum initiation interval is SETTLE+2 cycles.

Boundary conditions:
- in_valid asserted outside IDLE: ignored, and the operand is not consumed.
- out_ready low in HOLD: stalls indefinitely with y0/y1 and out_valid stable.
- SETTLE = 1: capture occurs on the edge after accept.
- rst_n asserted mid-transaction: immediate abort to reset values; the in-flight result is lost.

## Test plan

- Reset release, SEED = 16'hACE1, accept a=1, b=0 on the first edge -> a0=1, a1=0, b0=0, b1=0, r0=r1=r2=0; out_valid rises 2 edges later with y0^y1 = 1.
- All four (a,b) pairs back-to-back, out_ready=1, SETTLE=2 -> y0^y1 = a^b each time and a0^a1=a, b0^b1=b; accepts spaced exactly 4 cycles apart.
- out_ready held low for 10 cycles in HOLD -> y0, y1, out_valid stable, in_ready=0, in_valid pulses ignored; release -> in_ready=1 on the next cycle.
- seed_load with seed_in=0 -> s becomes 16'hACE1; with seed_in=16'h0001, accept on the next edge -> a0=1, b0=0, r0=0.
- rst_n pulsed low during SETTLE -> all outputs 0 immediately, out_valid never asserts for that operand, and the next accept behaves as after power-up.
- 10k random operands with random out_ready stalls -> zero unmask mismatches; the LFSR state never reaches 0.

Source files
------------

// File: rtl/masked_xor_share_sequencer.sv
// Operand sharing front-end and output capture stage for a 2-share masked XOR gate.
// Shares and fresh randomness come from a free-running 16-bit Fibonacci LFSR.
module masked_xor_share_sequencer #(
   parameter logic [15:0] SEED   = 16'hACE1,
   parameter int unsigned SETTLE = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        a,
   input  logic        b,
   input  logic        seed_load,
   input  logic [15:0] seed_in,
   output logic        a0,
   output logic        a1,
   output logic        b0,
   output logic        b1,
   output logic        r0,
   output logic        r1,
   output logic        r2,
   input  logic        y0_in,
   input  logic        y1_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        y0,
   output logic        y1
);

   localparam int unsigned LFSR_W = 16;
   localparam int unsigned CNT_W  = 4;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_HOLD   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [LFSR_W-1:0]   lfsr_q;
   logic                fb;
   logic                accept_c;
   logic                capture_c;

   assign fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

   // LFSR steps every cycle; a reload takes priority and never leaves it at zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= SEED;
      end else if (seed_load) begin
         lfsr_q <= (seed_in == '0) ? SEED : seed_in;
      end else begin
         lfsr_q <= {lfsr_q[LFSR_W-2:0], fb};
      end
   end

   // State and settle counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state, counter and datapath strobes
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      accept_c  = 1'b0;
      capture_c = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               accept_c = 1'b1;
               cnt_d    = CNT_W'(SETTLE - 1);
               state_d  = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (cnt_q == '0) begin
               capture_c = 1'b1;
               state_d   = S_HOLD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_HOLD: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Handshake outputs registered from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         in_ready  <= (state_d == S_IDLE);
         out_valid <= (state_d == S_HOLD);
      end
   end

   // Gate inputs only change on accept so they stay quiet through settle and hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a0 <= 1'b0;
         a1 <= 1'b0;
         b0 <= 1'b0;
         b1 <= 1'b0;
         r0 <= 1'b0;
         r1 <= 1'b0;
         r2 <= 1'b0;
      end else if (accept_c) begin
         a0 <= lfsr_q[0];
         a1 <= a ^ lfsr_q[0];
         b0 <= lfsr_q[1];
         b1 <= b ^ lfsr_q[1];
         r0 <= lfsr_q[2];
         r1 <= lfsr_q[3];
         r2 <= lfsr_q[4];
      end
   end

   // Output shares captured separately; never recombined here
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y0 <= 1'b0;
         y1 <= 1'b0;
      end else if (capture_c) begin
         y0 <= y0_in;
         y1 <= y1_in;
      end
   end

endmodule

// File: tb/tb_masked_xor_share_sequencer.sv
// Bench for masked_xor_share_sequencer: directed scenarios plus random traffic
// compared every cycle against a transaction-level model.
module tb_masked_xor_share_sequencer;

   localparam logic [15:0] SEED   = 16'hACE1;
   localparam int unsigned SETTLE = 2;

   logic        clk;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic        a, b;
   logic        seed_load;
   logic [15:0] seed_in;
   logic        a0, a1, b0, b1, r0, r1, r2;
   logic        y0_in, y1_in;
   logic        out_valid, out_ready;
   logic        y0, y1;

   masked_xor_share_sequencer #(.SEED(SEED), .SETTLE(SETTLE)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b),
      .seed_load(seed_load), .seed_in(seed_in),
      .a0(a0), .a1(a1), .b0(b0), .b1(b1),
      .r0(r0), .r1(r1), .r2(r2),
      .y0_in(y0_in), .y1_in(y1_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .y0(y0), .y1(y1)
   );

   // Masked XOR gate: refreshed with r0 on both shares
   assign y0_in = a0 ^ b0 ^ r0;
   assign y1_in = a1 ^ b1 ^ r0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int last_acc = 0;
   int gap      = 0;
   int n_acc    = 0;
   logic accepted = 1'b0;

   // Reference model: operation-level view (waiting count, holding flag)
   logic [15:0] m_s;
   int          m_wait;
   logic        m_hold;
   logic        m_a0, m_a1, m_b0, m_b1, m_r0, m_r1, m_r2;
   logic        m_y0, m_y1, m_aop, m_bop;
   wire         m_idle = (m_wait == 0) && !m_hold;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_s <= SEED; m_wait <= 0; m_hold <= 1'b0;
         m_a0 <= 1'b0; m_a1 <= 1'b0; m_b0 <= 1'b0; m_b1 <= 1'b0;
         m_r0 <= 1'b0; m_r1 <= 1'b0; m_r2 <= 1'b0;
         m_y0 <= 1'b0; m_y1 <= 1'b0; m_aop <= 1'b0; m_bop <= 1'b0;
      end else begin
         if (m_hold) begin
            if (out_ready) m_hold <= 1'b0;
         end else if (m_wait > 0) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) begin
               m_hold <= 1'b1;
               m_y0   <= m_a0 ^ m_b0 ^ m_r0;
               m_y1   <= m_a1 ^ m_b1 ^ m_r0;
            end
         end else if (in_valid) begin
            m_wait <= SETTLE;
            m_aop <= a; m_bop <= b;
            m_a0 <= m_s[0]; m_a1 <= a ^ m_s[0];
            m_b0 <= m_s[1]; m_b1 <= b ^ m_s[1];
            m_r0 <= m_s[2]; m_r1 <= m_s[3]; m_r2 <= m_s[4];
         end
         if (seed_load) m_s <= (seed_in != 16'h0) ? seed_in : SEED;
         else           m_s <= {m_s[14:0], m_s[15] ^ m_s[13] ^ m_s[12] ^ m_s[10]};
      end
   end

   task automatic check(input string tag, input logic got, input logic exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic check_all();
      check("in_ready", in_ready, m_idle);
      check("out_valid", out_valid, m_hold);
      check("a0", a0, m_a0);
      check("a1", a1, m_a1);
      check("b0", b0, m_b0);
      check("b1", b1, m_b1);
      check("r0", r0, m_r0);
      check("r1", r1, m_r1);
      check("r2", r2, m_r2);
      check("y0", y0, m_y0);
      check("y1", y1, m_y1);
      check("a_unshare", a0 ^ a1, m_aop);
      check("b_unshare", b0 ^ b1, m_bop);
      if (out_valid) check("y_unmask", y0 ^ y1, m_aop ^ m_bop);
   endtask

   // One clock: note whether the current drive is accepted, then check after the edge
   task automatic tick();
      accepted = rst_n && in_valid && in_ready;
      if (accepted) begin
         gap      = cyc - last_acc;
         last_acc = cyc;
         n_acc++;
      end
      @(negedge clk);
      cyc++;
      check_all();
   endtask

   task automatic wait_accept(input string tag);
      int k = 0;
      do begin
         tick();
         k++;
      end while (!accepted && k < 20);
      check(tag, accepted, 1'b1);
   endtask

   // Expects idle, fresh SEED state, in_valid=1, a=1, b=0, out_ready=1
   task automatic first_accept(input string tag);
      tick();
      check({tag, "_accepted"}, accepted, 1'b1);
      in_valid = 1'b0;
      check({tag, "_a0"}, a0, 1'b1);
      check({tag, "_a1"}, a1, 1'b0);
      check({tag, "_b0"}, b0, 1'b0);
      check({tag, "_b1"}, b1, 1'b0);
      check({tag, "_r0"}, r0, 1'b0);
      check({tag, "_r1"}, r1, 1'b0);
      check({tag, "_r2"}, r2, 1'b0);
      tick();
      check({tag, "_ov_early"}, out_valid, 1'b0);
      tick();
      check({tag, "_ov_rise"}, out_valid, 1'b1);
      check({tag, "_unmask"}, y0 ^ y1, 1'b1);
      tick();
      tick();
      check({tag, "_ready_back"}, in_ready, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; a = 1'b0; b = 1'b0;
      seed_load = 1'b0; seed_in = 16'h0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_a1", a1, 1'b0);
      check("rst_y0", y0, 1'b0);

      // Power-up transaction
      rst_n = 1'b1; in_valid = 1'b1; a = 1'b1; b = 1'b0;
      #1 check("rst_in_ready", in_ready, 1'b1);
      first_accept("pwr");

      // All four operand pairs back-to-back
      in_valid = 1'b1; out_ready = 1'b1;
      for (int p = 0; p < 4; p++) begin
         a = p[1]; b = p[0];
         wait_accept("b2b_accept");
         if (p > 0) check("b2b_gap4", gap == 4, 1'b1);
      end
      in_valid = 1'b0;
      repeat (4) tick();

      // Downstream stall in HOLD
      out_ready = 1'b0; in_valid = 1'b1; a = 1'b0; b = 1'b1;
      wait_accept("stall_accept");
      in_valid = 1'b0;
      repeat (2) tick();
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'($urandom); a = 1'($urandom); b = 1'($urandom);
         tick();
         check("stall_ov", out_valid, 1'b1);
         check("stall_in_ready", in_ready, 1'b0);
         check("stall_unmask", y0 ^ y1, 1'b1);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      check("release_in_ready", in_ready, 1'b1);

      // Reload with zero falls back to SEED
      seed_load = 1'b1; seed_in = 16'h0;
      tick();
      seed_load = 1'b0; in_valid = 1'b1; a = 1'b1; b = 1'b0;
      tick();
      check("seed0_accepted", accepted, 1'b1);
      in_valid = 1'b0;
      check("seed0_a0", a0, 1'b1);
      check("seed0_b0", b0, 1'b0);
      check("seed0_r0", r0, 1'b0);
      check("seed0_r2", r2, 1'b0);
      repeat (4) tick();

      // Reload with 16'h0001
      seed_load = 1'b1; seed_in = 16'h0001;
      tick();
      seed_load = 1'b0; in_valid = 1'b1; a = 1'b0; b = 1'b1;
      tick();
      check("seed1_accepted", accepted, 1'b1);
      in_valid = 1'b0;
      check("seed1_a0", a0, 1'b1);
      check("seed1_a1", a1, 1'b1);
      check("seed1_b0", b0, 1'b0);
      check("seed1_b1", b1, 1'b1);
      check("seed1_r0", r0, 1'b0);
      repeat (4) tick();

      // Reset pulse during SETTLE
      in_valid = 1'b1; a = 1'b1; b = 1'b1;
      wait_accept("mid_accept");
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("midrst_a0", a0, 1'b0);
      check("midrst_a1", a1, 1'b0);
      check("midrst_b1", b1, 1'b0);
      check("midrst_r0", r0, 1'b0);
      check("midrst_ov", out_valid, 1'b0);
      tick();
      rst_n = 1'b1; in_valid = 1'b1; a = 1'b1; b = 1'b0;
      first_accept("post_rst");

      // Random traffic with stalls and occasional reloads
      begin
         int target;
         target = n_acc + 10000;
         while (n_acc < target && cyc < 90000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = 1'($urandom);
            b         = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            seed_load = ($urandom_range(0, 63) == 0);
            seed_in   = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            tick();
         end
         check("random_all_accepted", n_acc >= target, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
